// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch (IF) stage of the MUSA pipeline.
//
// Owns the PC and drives the instruction-memory handshake. It registers each
// fetched word into the IF/ID slot and selects the next PC from the redirect
// controls decoded in ID. It also holds a small return-address stack.
//
// Ports
//   clk, rst          rising-edge clock; asynchronous active-low reset
//   pc_write          1 = advance, 0 = stall (hold PC and IF/ID slot)
//   pc_src            0 pc+4, 1 branch, 2 jump, 3 register, 4 stack top, 5-7 as 0
//   push, pop         return-stack strobes from ID (call / return)
//   branch_offset     sign-extended word offset
//   jump_target       jump target, already shifted left by 2
//   reg_target        register-sourced target
//   imem_req/addr     fetch request and address
//   imem_ready/rdata  response strobe and instruction word
//   instruction       IF/ID instruction register
//   pc_out            PC of the instruction in the IF/ID slot
//   instr_valid       the IF/ID slot holds a real fetch
//   stack_overflow    one-cycle pulse on a push while the stack is full
//   stack_underflow   one-cycle pulse on a pop while the stack is empty
//   dbg_state         current FSM state, for observation only
//
// Handshake: imem_req/imem_addr form a request that completes in the cycle
// imem_ready=1. Once raised, a request is neither withdrawn nor readdressed
// until it completes. The only exception is reset, which abandons it.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          STACK_DEPTH = 8,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic [2:0]  pc_src,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] branch_offset,
    input  logic [31:0] jump_target,
    input  logic [31:0] reg_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    output logic        stack_overflow,
    output logic        stack_underflow,
    output logic [1:0]  dbg_state
);

    localparam int AW  = $clog2(STACK_DEPTH);
    localparam int SPW = AW + 1;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    instr_q, instr_d;
    logic [31:0]    pc_out_q, pc_out_d;
    logic           valid_q, valid_d;
    logic [31:0]    buf_q, buf_d;
    logic [31:0]    bufpc_q, bufpc_d;
    logic [31:0]    pend_q, pend_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;
    logic [31:0]    stack_q [STACK_DEPTH];

    logic [31:0]    link_addr;
    logic [31:0]    stack_top;
    logic [31:0]    target;
    logic [AW-1:0]  top_idx;
    logic           stack_empty;
    logic           stack_full;
    logic           redirect;
    logic           stack_en;

    // Redirect targets are relative to the instruction sitting in ID.
    assign link_addr   = pc_out_q + 32'd4;
    assign stack_empty = (sp_q == '0);
    assign stack_full  = (sp_q == SPW'(STACK_DEPTH));
    assign top_idx     = sp_q[AW-1:0] - AW'(1);
    assign stack_top   = stack_empty ? RESET_PC : stack_q[top_idx];
    assign redirect    = (pc_src >= 3'd1) && (pc_src <= 3'd4);
    // Controls from ID are meaningless while an abandoned request drains.
    assign stack_en    = pc_write && (state_q != S_DRAIN);

    always_comb begin
        target = pc_q + 32'd4;
        case (pc_src)
            3'd1:    target = link_addr + (branch_offset << 2);
            3'd2:    target = {link_addr[31:28], jump_target[27:0]};
            3'd3:    target = reg_target;
            3'd4:    target = stack_top;
            default: target = pc_q + 32'd4;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_BOOT;
        else      state_q <= state_d;
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ready && !pc_write)            state_d = S_HOLD;
                else if (pc_write && redirect && !imem_ready) state_d = S_DRAIN;
            end
            S_HOLD:  if (pc_write)   state_d = S_FETCH;
            S_DRAIN: if (imem_ready) state_d = S_FETCH;
            default: state_d = S_BOOT;
        endcase
    end

    // FSM: outputs and datapath next state
    always_comb begin
        imem_req = (state_q == S_FETCH) || (state_q == S_DRAIN);
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        buf_d    = buf_q;
        bufpc_d  = bufpc_q;
        pend_d   = pend_q;
        case (state_q)
            S_FETCH: begin
                if (pc_write) begin
                    if (redirect) begin
                        // Flush; a response arriving now belongs to the wrong path.
                        instr_d = NOP_WORD;
                        valid_d = 1'b0;
                        if (imem_ready) pc_d   = target;
                        else            pend_d = target;
                    end else if (imem_ready) begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = pc_q + 32'd4;
                    end else begin
                        instr_d = NOP_WORD;
                        valid_d = 1'b0;
                    end
                end else if (imem_ready) begin
                    // Stalled: park the word until ID can take it.
                    buf_d   = imem_rdata;
                    bufpc_d = pc_q;
                end
            end
            S_HOLD: begin
                if (pc_write) begin
                    if (redirect) begin
                        pc_d    = target;
                        instr_d = NOP_WORD;
                        valid_d = 1'b0;
                    end else begin
                        instr_d  = buf_q;
                        pc_out_d = bufpc_q;
                        valid_d  = 1'b1;
                        pc_d     = bufpc_q + 32'd4;
                    end
                end
            end
            S_DRAIN: if (imem_ready) pc_d = pend_q;
            default: ;
        endcase
    end

    // Return stack pointer and status pulses
    always_comb begin
        sp_d  = sp_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (stack_en) begin
            if (push && pop) begin
                // Swap the top; on an empty stack this is underflow plus a push.
                if (stack_empty) begin
                    sp_d  = SPW'(1);
                    unf_d = 1'b1;
                end
            end else if (push) begin
                if (stack_full) ovf_d = 1'b1;
                else            sp_d  = sp_q + SPW'(1);
            end else if (pop) begin
                if (stack_empty) unf_d = 1'b1;
                else             sp_d  = sp_q - SPW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (stack_en && push) begin
            if (pop && !stack_empty)  stack_q[top_idx]        <= link_addr;
            else if (!stack_full)     stack_q[sp_q[AW-1:0]]   <= link_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            instr_q  <= NOP_WORD;
            pc_out_q <= 32'h0;
            valid_q  <= 1'b0;
            buf_q    <= 32'h0;
            bufpc_q  <= 32'h0;
            pend_q   <= 32'h0;
            sp_q     <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            buf_q    <= buf_d;
            bufpc_q  <= bufpc_d;
            pend_q   <= pend_d;
            sp_q     <= sp_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign imem_addr       = pc_q;
    assign instruction     = instr_q;
    assign pc_out          = pc_out_q;
    assign instr_valid     = valid_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [1:0]  ST_HOLD  = 2'd2;
    localparam logic [1:0]  ST_DRAIN = 2'd3;

    logic        clk;
    logic        rst;
    logic        pc_write;
    logic [2:0]  pc_src;
    logic        push;
    logic        pop;
    logic [31:0] branch_offset;
    logic [31:0] jump_target;
    logic [31:0] reg_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        stack_overflow;
    logic        stack_underflow;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    // Scoreboard entries: {pc, instruction word}
    logic [63:0] exp_q[$];
    logic [31:0] exp_addr;

    fetch_stage #(
        .RESET_PC    (RESET_PC),
        .STACK_DEPTH (8),
        .NOP_WORD    (NOP_WORD)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_write        (pc_write),
        .pc_src          (pc_src),
        .push            (push),
        .pop             (pop),
        .branch_offset   (branch_offset),
        .jump_target     (jump_target),
        .reg_target      (reg_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .instruction     (instruction),
        .pc_out          (pc_out),
        .instr_valid     (instr_valid),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memory model ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        logic [63:0] e;
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_instr"}, instruction, e[31:0]);
            chk({tag, "_pcout"}, pc_out, e[63:32]);
        end
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
        chk({tag, "_nop"}, instruction, NOP_WORD);
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted sequential fetch at exp_addr.
    task automatic step_accept(input string tag, input logic [2:0] src);
        pc_src     = src;
        imem_ready = 1'b1;
        pc_write   = 1'b1;
        exp_q.push_back({exp_addr, mem_word(exp_addr)});
        tick();
        push   = 1'b0;
        pop    = 1'b0;
        pc_src = 3'd0;
        sb_check(tag);
        exp_addr = exp_addr + 32'd4;
        chk({tag, "_addr"}, imem_addr, exp_addr);
    endtask

    // One redirect while the memory responds; the response is dropped.
    task automatic step_redirect(input string tag, input logic [2:0] src, input logic [31:0] tgt);
        pc_src     = src;
        imem_ready = 1'b1;
        pc_write   = 1'b1;
        tick();
        push   = 1'b0;
        pop    = 1'b0;
        pc_src = 3'd0;
        chk_bubble(tag);
        exp_addr = tgt;
        chk({tag, "_addr"}, imem_addr, exp_addr);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst           = 1'b0;
        pc_write      = 1'b1;
        pc_src        = 3'd0;
        push          = 1'b0;
        pop           = 1'b0;
        branch_offset = 32'h0;
        jump_target   = 32'h0;
        reg_target    = 32'h0;
        imem_ready    = 1'b1;
        exp_addr      = RESET_PC;

        // Reset state
        tick();
        tick();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_pcout", pc_out, 32'h0);
        chk_bubble("rst");
        chk("rst_ovf", {31'b0, stack_overflow}, 32'd0);
        chk("rst_unf", {31'b0, stack_underflow}, 32'd0);

        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("boot_req", {31'b0, imem_req}, 32'd1);
        chk("boot_addr", imem_addr, 32'h0);
        chk_bubble("boot");

        // Sequential fetch 0x00..0x40; pc_src=5 at 0x20 behaves as pc+4
        for (int i = 0; i <= 16; i++) step_accept("seq", (i == 8) ? 3'd5 : 3'd0);

        // Backward branch from pc_out=0x40: 0x44 + (-2<<2) = 0x3C
        branch_offset = 32'hFFFF_FFFE;
        step_redirect("br", 3'd1, 32'h3C);
        step_accept("br_tgt", 3'd0);

        // Redirect during a slow response: address held, response dropped
        reg_target = 32'h200;
        pc_src     = 3'd3;
        imem_ready = 1'b0;
        pc_write   = 1'b1;
        tick();
        pc_src = 3'd0;
        chk_bubble("drain0");
        chk("drain0_state", {30'b0, dbg_state}, {30'b0, ST_DRAIN});
        for (int i = 1; i < 3; i++) begin
            tick();
            chk("drain_req", {31'b0, imem_req}, 32'd1);
            chk("drain_addr", imem_addr, 32'h40);
        end
        imem_ready = 1'b1;
        tick();
        chk_bubble("drain_done");
        exp_addr = 32'h200;
        chk("drain_tgt_addr", imem_addr, exp_addr);
        step_accept("jr_tgt", 3'd0);

        // Stall while the memory responds: word parked in the hold buffer
        imem_ready = 1'b1;
        pc_write   = 1'b0;
        tick();
        chk("hold_req", {31'b0, imem_req}, 32'd0);
        chk("hold_state", {30'b0, dbg_state}, {30'b0, ST_HOLD});
        chk("hold_instr", instruction, mem_word(32'h200));
        chk("hold_pcout", pc_out, 32'h200);
        imem_ready = 1'b0;
        tick();
        chk("hold2_req", {31'b0, imem_req}, 32'd0);
        chk("hold2_instr", instruction, mem_word(32'h200));
        pc_write = 1'b1;
        exp_q.push_back({32'h204, mem_word(32'h204)});
        tick();
        sb_check("hold_rel");
        exp_addr = 32'h208;
        chk("hold_rel_addr", imem_addr, exp_addr);
        chk("hold_rel_req", {31'b0, imem_req}, 32'd1);

        // Bubble: no response, no redirect
        imem_ready = 1'b0;
        tick();
        chk_bubble("bubble");
        chk("bubble_addr", imem_addr, 32'h208);
        step_accept("after_bubble", 3'd0);

        // Jump keeps the upper nibble of pc_out+4
        jump_target = 32'hF000_0120;
        step_redirect("jmp", 3'd2, 32'h0000_0120);
        reg_target = 32'h100;
        step_redirect("jr", 3'd3, 32'h100);
        step_accept("call_site", 3'd0);

        // Call at pc_out=0x100, return later
        push = 1'b1;
        step_accept("call", 3'd0);
        step_accept("callee", 3'd0);
        pop = 1'b1;
        step_redirect("ret", 3'd4, 32'h104);
        chk("ret_ovf", {31'b0, stack_overflow}, 32'd0);
        chk("ret_unf", {31'b0, stack_underflow}, 32'd0);
        step_accept("ret_tgt", 3'd0);

        // Nine pushes into eight entries
        for (int k = 0; k < 9; k++) begin
            push = 1'b1;
            step_accept("fill", 3'd0);
            if (k == 7) chk("fill_no_ovf", {31'b0, stack_overflow}, 32'd0);
        end
        chk("ovf_pulse", {31'b0, stack_overflow}, 32'd1);

        // Unwind: entries come back newest first
        for (int j = 0; j < 8; j++) begin
            pop = 1'b1;
            step_redirect("unwind", 3'd4, 32'h108 + 32'(4 * (7 - j)));
            if (j == 0) chk("ovf_clear", {31'b0, stack_overflow}, 32'd0);
        end
        chk("unwind_unf", {31'b0, stack_underflow}, 32'd0);
        pop = 1'b1;
        step_redirect("empty_pop", 3'd4, RESET_PC);
        chk("unf_pulse", {31'b0, stack_underflow}, 32'd1);
        step_accept("after_unf", 3'd0);
        chk("unf_clear", {31'b0, stack_underflow}, 32'd0);

        // Push+pop on empty: underflow plus a push of pc_out+4 (= 4)
        push = 1'b1;
        pop  = 1'b1;
        step_redirect("swap_empty", 3'd4, RESET_PC);
        chk("swap_unf", {31'b0, stack_underflow}, 32'd1);
        pop = 1'b1;
        step_redirect("swap_ret", 3'd4, 32'h4);
        chk("swap_ret_unf", {31'b0, stack_underflow}, 32'd0);

        // Reset mid-request drops the request without a clock edge
        chk("pre_arst_req", {31'b0, imem_req}, 32'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("arst_req", {31'b0, imem_req}, 32'd0);
        chk("arst_addr", imem_addr, RESET_PC);
        chk("arst_valid", {31'b0, instr_valid}, 32'd0);
        rst = 1'b1;
        tick();

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
